// File: rtl/mii_pkg.sv
// Shared codes, state/error encodings and helpers for the MII frame checker.
package mii_pkg;

    localparam logic [7:0] IdleCode     = 8'h07;
    localparam logic [7:0] StartCode    = 8'hFB;
    localparam logic [7:0] PreambleCode = 8'h55;
    localparam logic [7:0] SfdCode      = 8'hD5;
    localparam logic [7:0] DstAddrCode  = 8'h01;
    localparam logic [7:0] SrcAddrCode  = 8'h02;
    localparam logic [7:0] LenTypCode   = 8'h03;
    localparam logic [7:0] FcsCode      = 8'h04;
    localparam logic [7:0] TermCode     = 8'hFD;

    typedef enum logic [2:0] {
        StIdle, StPre, StSfd, StDst, StSrc, StLen, StPay, StErrw
    } mii_state_e;

    typedef enum logic [3:0] {
        ErrNone  = 4'd0,
        ErrPre   = 4'd1,
        ErrSfd   = 4'd2,
        ErrDst   = 4'd3,
        ErrSrc   = 4'd4,
        ErrLen   = 4'd5,
        ErrCtrl  = 4'd6,
        ErrShort = 4'd7,
        ErrLong  = 4'd8,
        ErrFcs   = 4'd9
    } mii_err_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mii_fcs_strip.sv
// Delay line that holds back the trailing FCS bytes of the payload stream; a byte is
// released only once DEPTH newer bytes have arrived behind it.
module mii_fcs_strip #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  FCS_CODE = 8'h04
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_all_fcs
);

    localparam int unsigned FillW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][7:0] line_q, line_d;
    logic [FillW-1:0]      fill_q, fill_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  full;

    assign full = (fill_q == FillW'(DEPTH));

    always_comb begin
        line_d  = line_q;
        fill_d  = fill_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (i_flush) begin
            line_d = '0;
            fill_d = '0;
        end else if (i_push) begin
            line_d[0] = i_data;
            for (int i = 1; i < DEPTH; i++) begin
                line_d[i] = line_q[i-1];
            end
            if (full) begin
                data_d  = line_q[DEPTH-1];
                valid_d = 1'b1;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Only meaningful once the line holds a full FCS worth of bytes.
    always_comb begin
        o_all_fcs = full;
        for (int i = 0; i < DEPTH; i++) begin
            if (line_q[i] != FCS_CODE) begin
                o_all_fcs = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            line_q  <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/mii_frame_checker.sv
// Receive-side MII frame parser/checker: strips FCS, reports per-frame status and counts.
// Define MII_CHECKER_STATS_EN to add per-error histograms and good-frame min/max length.
module mii_frame_checker
    import mii_pkg::*;
#(
    parameter int unsigned PREAMBLE_CYCLES = 7,
    parameter int unsigned DST_ADDR_CYCLES = 6,
    parameter int unsigned SRC_ADDR_CYCLES = 6,
    parameter int unsigned LEN_TYP_CYCLES  = 2,
    parameter int unsigned DATA_CYCLES     = 46,
    parameter int unsigned MAX_DATA_CYCLES = 1500,
    parameter int unsigned FCS_CYCLES      = 4,
    parameter logic [7:0]  IDLE_CODE       = IdleCode,
    parameter logic [7:0]  START_CODE      = StartCode,
    parameter logic [7:0]  PREAMBLE_CODE   = PreambleCode,
    parameter logic [7:0]  SFD_CODE        = SfdCode,
    parameter logic [7:0]  DST_ADDR_CODE   = DstAddrCode,
    parameter logic [7:0]  SRC_ADDR_CODE   = SrcAddrCode,
    parameter logic [7:0]  LEN_TYP_CODE    = LenTypCode,
    parameter logic [7:0]  FCS_CODE        = FcsCode,
    parameter logic [7:0]  TERMINATE_CODE  = TermCode
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic [7:0]   i_rx_data,
    input  logic [7:0]   i_rx_ctrl,
    output logic [7:0]   o_data,
    output logic         o_data_valid,
    output logic         o_frame_done,
    output logic         o_frame_good,
    output logic [3:0]   o_err_code,
    output logic [15:0]  o_payload_len,
    output logic [15:0]  o_good_cnt,
    output logic [15:0]  o_bad_cnt,
    output logic         o_busy
`ifdef MII_CHECKER_STATS_EN
    ,
    output logic [255:0] o_err_hist,
    output logic [15:0]  o_min_len,
    output logic [15:0]  o_max_len
`endif
);

    localparam logic [15:0] PreLen = 16'(PREAMBLE_CYCLES);
    localparam logic [15:0] DstLen = 16'(DST_ADDR_CYCLES);
    localparam logic [15:0] SrcLen = 16'(SRC_ADDR_CYCLES);
    localparam logic [15:0] LtLen  = 16'(LEN_TYP_CYCLES);
    localparam logic [15:0] FcsLen = 16'(FCS_CYCLES);
    localparam logic [15:0] MinPay = 16'(DATA_CYCLES + FCS_CYCLES);
    localparam logic [15:0] MaxPay = 16'(MAX_DATA_CYCLES + FCS_CYCLES);

    logic [7:0]  rx_data_q;
    logic        rx_ctrl_q;
    mii_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        done_q, done_d, good_q, good_d;
    logic [3:0]  err_q, err_d;
    logic [15:0] len_q, len_d;
    logic [15:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

    logic [7:0]  fld_code;
    logic [15:0] fld_len;
    mii_err_e    fld_err, err_now;
    mii_state_e  fld_next;
    logic        term, push, flush, all_fcs;

    assign cnt_inc = cnt_q + 16'd1;

    // Fixed-content header fields share one check; this selects the field being parsed.
    always_comb begin
        fld_code = PREAMBLE_CODE;
        fld_len  = PreLen;
        fld_err  = ErrPre;
        fld_next = StSfd;
        case (state_q)
            StSfd: begin
                fld_code = SFD_CODE;
                fld_len  = 16'd1;
                fld_err  = ErrSfd;
                fld_next = StDst;
            end
            StDst: begin
                fld_code = DST_ADDR_CODE;
                fld_len  = DstLen;
                fld_err  = ErrDst;
                fld_next = StSrc;
            end
            StSrc: begin
                fld_code = SRC_ADDR_CODE;
                fld_len  = SrcLen;
                fld_err  = ErrSrc;
                fld_next = StLen;
            end
            StLen: begin
                fld_code = LEN_TYP_CODE;
                fld_len  = LtLen;
                fld_err  = ErrLen;
                fld_next = StPay;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        good_d     = 1'b0;
        err_d      = err_q;
        len_d      = len_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_now    = ErrNone;
        term       = 1'b0;
        push       = 1'b0;
        case (state_q)
            StIdle: begin
                if (rx_ctrl_q && rx_data_q == START_CODE) begin
                    state_d = StPre;
                end
            end
            StPre, StSfd, StDst, StSrc, StLen: begin
                if (rx_ctrl_q) begin
                    err_now = ErrCtrl;
                end else if (rx_data_q != fld_code) begin
                    err_now = fld_err;
                end else if (cnt_inc == fld_len) begin
                    state_d = fld_next;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPay: begin
                if (rx_ctrl_q) begin
                    if (rx_data_q == TERMINATE_CODE) begin
                        term    = 1'b1;
                        state_d = StIdle;
                        len_d   = (cnt_q >= FcsLen) ? cnt_q - FcsLen : 16'd0;
                        if (cnt_q < MinPay) begin
                            err_now = ErrShort;
                        end else if (!all_fcs) begin
                            err_now = ErrFcs;
                        end
                    end else begin
                        err_now = ErrCtrl;
                    end
                end else if (cnt_inc > MaxPay) begin
                    err_now = ErrLong;
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_inc;
                end
            end
            StErrw: begin
                if (rx_ctrl_q) begin
                    if (rx_data_q == TERMINATE_CODE || rx_data_q == IDLE_CODE) begin
                        state_d = StIdle;
                    end else if (rx_data_q == START_CODE) begin
                        state_d = StPre;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A terminate-time error has already consumed the frame end, so skip the wait state.
        if (err_now != ErrNone) begin
            done_d    = 1'b1;
            err_d     = err_now;
            bad_cnt_d = sat_inc16(bad_cnt_q);
            if (!term) begin
                state_d = StErrw;
            end
        end else if (term) begin
            done_d     = 1'b1;
            good_d     = 1'b1;
            err_d      = ErrNone;
            good_cnt_d = sat_inc16(good_cnt_q);
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign flush = (state_q == StPay) && (state_d != StPay);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            rx_data_q  <= '0;
            rx_ctrl_q  <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            good_q     <= 1'b0;
            err_q      <= '0;
            len_q      <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            rx_data_q  <= i_rx_data;
            rx_ctrl_q  <= |i_rx_ctrl;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            good_q     <= good_d;
            err_q      <= err_d;
            len_q      <= len_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    mii_fcs_strip #(
        .DEPTH    (FCS_CYCLES),
        .FCS_CODE (FCS_CODE)
    ) u_strip (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_flush   (flush),
        .i_push    (push),
        .i_data    (rx_data_q),
        .o_data    (o_data),
        .o_valid   (o_data_valid),
        .o_all_fcs (all_fcs)
    );

    assign o_frame_done  = done_q;
    assign o_frame_good  = good_q;
    assign o_err_code    = err_q;
    assign o_payload_len = len_q;
    assign o_good_cnt    = good_cnt_q;
    assign o_bad_cnt     = bad_cnt_q;
    assign o_busy        = (state_q != StIdle);

`ifdef MII_CHECKER_STATS_EN
    logic [15:0] hist_q [16];
    logic [15:0] hist_d [16];
    logic [15:0] min_len_q, min_len_d, max_len_q, max_len_d;

    always_comb begin
        hist_d    = hist_q;
        min_len_d = min_len_q;
        max_len_d = max_len_q;
        if (done_d && !good_d) begin
            hist_d[err_d] = sat_inc16(hist_q[err_d]);
        end
        if (done_d && good_d) begin
            if (len_d < min_len_q) min_len_d = len_d;
            if (len_d > max_len_q) max_len_d = len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                hist_q[i] <= '0;
            end
            min_len_q <= 16'hFFFF;
            max_len_q <= '0;
        end else begin
            hist_q    <= hist_d;
            min_len_q <= min_len_d;
            max_len_q <= max_len_d;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_hist
        assign o_err_hist[g*16 +: 16] = hist_q[g];
    end
    assign o_min_len = min_len_q;
    assign o_max_len = max_len_q;
`endif

endmodule

// File: doc/mii_frame_checker.md
Name: mii_frame_checker

Overview:
- Receive-side counterpart of the Ethernet MII frame generator.
- Consumes the 8-bit data/control byte stream, parses IDLE / START / preamble / SFD / DST / SRC / LEN-TYPE / payload / FCS / TERMINATE, and checks each field's length and code.
- Forwards payload bytes with FCS stripped and reports per-frame good/bad status with an error code.
- Sits at the far end of the MII link in agent benches: scoreboard front-end and DUT-output checker.

Parameters:
- PREAMBLE_CYCLES, 7, number of 0x55 bytes after START, before SFD
- DST_ADDR_CYCLES, 6, DST field length
- SRC_ADDR_CYCLES, 6, SRC field length
- LEN_TYP_CYCLES, 2, length/type field length
- DATA_CYCLES, 46, minimum payload bytes
- MAX_DATA_CYCLES, 1500, maximum payload bytes
- FCS_CYCLES, 4, FCS bytes, also the depth of the strip delay line
- IDLE_CODE 8'h07, START_CODE 8'hFB, PREAMBLE_CODE 8'h55, SFD_CODE 8'hD5, DST_ADDR_CODE 8'h01, SRC_ADDR_CODE 8'h02, LEN_TYP_CODE 8'h03, FCS_CODE 8'h04, TERMINATE_CODE 8'hFD: expected byte values

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rx_data  in  8  received byte
- i_rx_ctrl  in  8  control flags; byte is a control character iff any bit is set
- o_data  out  8  payload byte, FCS stripped
- o_data_valid  out  1  o_data qualifier
- o_frame_done  out  1  1-cycle pulse at end of any frame attempt
- o_frame_good  out  1  valid with o_frame_done; 1 = no error
- o_err_code  out  4  held until the next o_frame_done
- o_payload_len  out  16  payload byte count of the last frame, held
- o_good_cnt  out  16  good frames, saturating at 16'hFFFF
- o_bad_cnt  out  16  bad frames, saturating at 16'hFFFF
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: FSM to IDLE; delay line, field counters and all outputs cleared to 0; no pulse is issued for a frame aborted by reset.
- Input is registered once; all checks act on the registered byte. Timing references below are in cycles after the byte appears at the input.
- States and transitions:
  - IDLE: ctrl+START_CODE -> PRE. IDLE_CODE or any data byte -> stay (no error).
  - PRE: needs exactly PREAMBLE_CYCLES data bytes of PREAMBLE_CODE, else err 1. Next byte must be data SFD_CODE, else err 2; on pass -> DST.
  - DST, SRC, LEN: each needs its CYCLES count of data bytes equal to its code, else err 3 / 4 / 5 respectively.
  - PAY: every data byte enters the FCS_CYCLES-deep shift line.
    - When the line is full, the byte shifted out drives o_data with o_data_valid=1. Payload latency is FCS_CYCLES+2 cycles.
    - Count n = bytes received in PAY.
    - On ctrl+TERMINATE_CODE:
      - n-FCS_CYCLES < DATA_CYCLES -> err 7 (short).
      - Any line byte != FCS_CODE -> err 9.
      - Otherwise good.
      - o_payload_len = n-FCS_CYCLES, saturating at 0.
      - Then -> IDLE.
    - n > MAX_DATA_CYCLES+FCS_CYCLES -> err 8 immediately.
  - ERRW: entered on any error.
    - o_frame_done pulses at entry, with o_frame_good=0 and o_bad_cnt incremented.
    - Discards bytes until ctrl+TERMINATE_CODE or IDLE_CODE (-> IDLE) or ctrl+START_CODE (-> PRE, new frame).
- Any control byte other than the one expected in PRE/DST/SRC/LEN/PAY -> err 6. START inside a frame also gives err 6, and the following frame is not recovered.
- Error priority within one byte: 6 over field errors. Only the first error of a frame is reported.
- Good frame:
  - o_frame_done and o_frame_good = 1 one cycle after the TERMINATE byte is registered.
  - o_good_cnt increments; o_err_code = 0.
- Shift line is flushed, without output, on TERMINATE or on error. Bytes already output for a bad frame are not retracted.
- Counter arithmetic: field counters are 16-bit and clear on state entry.

Optional Feature:
- MII_CHECKER_STATS_EN defined:
  - Adds o_err_hist, 16x16-bit, flattened to 256 bits: one saturating counter per error code, indexed by o_err_code.
  - Adds o_min_len and o_max_len, each 16 bits, over good frames. Reset values: o_min_len 16'hFFFF, o_max_len 0.
- Macro undefined: these ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Package mii_pkg:
  - Default code constants.
  - State enum: IDLE, PRE, SFD, DST, SRC, LEN, PAY, ERRW.
  - Error-code enum: NONE=0, PRE=1, SFD=2, DST=3, SRC=4, LEN=5, CTRL=6, SHORT=7, LONG=8, FCS=9.
- Sub-module mii_fcs_strip: parameterised delay line with fill count, flush, and an "all bytes == FCS_CODE" compare output.

Test Plan:
- Generator default frame (START, 7x55, D5, 6x01, 6x02, 2x03, 46 payload, 4x04, FD) -> 46 o_data_valid beats, o_frame_good=1, o_payload_len=46, o_good_cnt=1.
- Sixth preamble byte 0x54 -> o_frame_done with err 1, o_bad_cnt=1; bytes discarded until FD; the next clean frame is good.
- Payload of 40 bytes -> err 7, o_payload_len=40. Payload of 1501 bytes -> err 8 raised at PAY byte 1505, before TERMINATE.
- Last FCS byte 0x05 -> err 9, with all 46 payload bytes still forwarded.
- START received during SRC -> err 6; i_rst asserted mid-PAY -> no o_frame_done, counters 0, o_busy=0 the next cycle.
- 65537 good frames (counter forced near wrap) -> o_good_cnt holds 16'hFFFF. With MII_CHECKER_STATS_EN: o_err_hist[9] counts FCS errors.
